// File: rtl/branch_sched_if.sv
// Decode-to-branch-scheduler bundle: branch request, operand forwarding,
// external comparator hookup, fetch redirect and resolution statistics.
interface branch_sched_if #(
    parameter int CNT_W = 16
);
    logic             br_valid;
    logic [3:0]       br_type;
    logic [31:0]      rs_val;
    logic [31:0]      rt_val;
    logic             rs_ready;
    logic             rt_ready;
    logic [31:0]      br_target;
    logic             exc_flush;
    logic [31:0]      cmp_rd1;
    logic [31:0]      cmp_rd2;
    logic [3:0]       cmp_type;
    logic             cmp_out;
    logic             stall_d;
    logic             redirect_valid;
    logic [31:0]      redirect_pc;
    logic [CNT_W-1:0] taken_cnt;
    logic [CNT_W-1:0] ntaken_cnt;
    logic [1:0]       dbg_state;

    // Decode / comparator side.
    modport master (
        output br_valid, br_type, rs_val, rt_val, rs_ready, rt_ready,
               br_target, exc_flush, cmp_out,
        input  cmp_rd1, cmp_rd2, cmp_type, stall_d, redirect_valid,
               redirect_pc, taken_cnt, ntaken_cnt, dbg_state
    );

    // Scheduler side.
    modport slave (
        input  br_valid, br_type, rs_val, rt_val, rs_ready, rt_ready,
               br_target, exc_flush, cmp_out,
        output cmp_rd1, cmp_rd2, cmp_type, stall_d, redirect_valid,
               redirect_pc, taken_cnt, ntaken_cnt, dbg_state
    );
endinterface

// File: rtl/branch_sched.sv
// Resolves decode-stage conditional branches through an external comparator,
// stalling decode while operands wait and issuing a one-cycle fetch redirect.
module branch_sched #(
    parameter int CNT_W = 16
) (
    input logic          clk,
    input logic          reset,
    branch_sched_if.slave br_if
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_CMP   = 2'd2,
        S_REDIR = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [3:0]       type_q, type_d;
    logic [31:0]      target_q, target_d;
    logic [31:0]      rs_q, rs_d;
    logic [31:0]      rt_q, rt_d;
    logic [CNT_W-1:0] taken_q, taken_d;
    logic [CNT_W-1:0] ntaken_q, ntaken_d;

    logic ops_ready;
    logic accept;
    logic load_ops;
    logic resolve;

    // Handshake: a branch is taken from decode in any IDLE cycle where
    // br_valid=1 and exc_flush=0; decode must hold it while stall_d=1, and
    // br_valid outside IDLE is ignored. Operands count only when both
    // rs_ready and rt_ready are 1 in the same cycle.
    assign ops_ready = br_if.rs_ready & br_if.rt_ready;
    assign accept    = (state_q == S_IDLE) & br_if.br_valid & ~br_if.exc_flush;
    assign load_ops  = ~br_if.exc_flush & ops_ready &
                       (((state_q == S_IDLE) & br_if.br_valid) | (state_q == S_WAIT));
    assign resolve   = (state_q == S_CMP) & ~br_if.exc_flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (br_if.exc_flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (br_if.br_valid) begin
                        state_d = ops_ready ? S_CMP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (ops_ready) begin
                        state_d = S_CMP;
                    end
                end
                S_CMP: begin
                    state_d = br_if.cmp_out ? S_REDIR : S_IDLE;
                end
                S_REDIR: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        type_d   = type_q;
        target_d = target_q;
        rs_d     = rs_q;
        rt_d     = rt_q;
        taken_d  = taken_q;
        ntaken_d = ntaken_q;
        if (accept) begin
            type_d   = br_if.br_type;
            target_d = br_if.br_target;
        end
        if (load_ops) begin
            rs_d = br_if.rs_val;
            rt_d = br_if.rt_val;
        end
        // Counters wrap naturally at 2^CNT_W.
        if (resolve) begin
            if (br_if.cmp_out) begin
                taken_d = taken_q + 1'b1;
            end else begin
                ntaken_d = ntaken_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            type_q   <= '0;
            target_q <= '0;
            rs_q     <= '0;
            rt_q     <= '0;
            taken_q  <= '0;
            ntaken_q <= '0;
        end else begin
            type_q   <= type_d;
            target_q <= target_d;
            rs_q     <= rs_d;
            rt_q     <= rt_d;
            taken_q  <= taken_d;
            ntaken_q <= ntaken_d;
        end
    end

    // Reset gates stall_d so decode is never held by a stale br_valid.
    always_comb begin
        br_if.stall_d        = 1'b0;
        br_if.redirect_valid = 1'b0;
        br_if.redirect_pc    = '0;
        if (reset && !br_if.exc_flush) begin
            case (state_q)
                S_IDLE:  br_if.stall_d = br_if.br_valid;
                S_WAIT:  br_if.stall_d = 1'b1;
                S_CMP:   br_if.stall_d = 1'b1;
                S_REDIR: begin
                    br_if.redirect_valid = 1'b1;
                    br_if.redirect_pc    = target_q;
                end
                default: br_if.stall_d = 1'b0;
            endcase
        end
        br_if.cmp_rd1    = rs_q;
        br_if.cmp_rd2    = rt_q;
        br_if.cmp_type   = type_q;
        br_if.taken_cnt  = taken_q;
        br_if.ntaken_cnt = ntaken_q;
        br_if.dbg_state  = state_q;
    end

endmodule

// File: tb/tb_branch_sched.sv
// Directed bench for branch_sched: table of single-branch vectors plus
// hand-written stall, flush, ignore, reset and counter-wrap sequences.
module tb_branch_sched;

    localparam int CW = 4;

    localparam logic [3:0] CMP_EQ  = 4'h1;
    localparam logic [3:0] CMP_NE  = 4'h2;
    localparam logic [3:0] CMP_GTZ = 4'h3;
    localparam logic [3:0] CMP_LEZ = 4'h4;
    localparam logic [3:0] CMP_GEZ = 4'h5;
    localparam logic [3:0] CMP_LTZ = 4'h6;
    localparam logic [3:0] CMP_BAD = 4'hF;

    localparam logic [31:0] ST_IDLE  = 32'd0;
    localparam logic [31:0] ST_WAIT  = 32'd1;
    localparam logic [31:0] ST_CMP   = 32'd2;
    localparam logic [31:0] ST_REDIR = 32'd3;

    typedef struct {
        logic [3:0]  br_type;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] target;
        logic        taken;
    } vec_t;

    logic clk;
    logic reset;
    logic cmp_force;
    logic cmp_model;

    int checks;
    int failures;
    logic [CW-1:0] exp_taken;
    logic [CW-1:0] exp_ntaken;
    logic [31:0]   exp_q[$];
    vec_t          vecs[11];

    branch_sched_if #(.CNT_W(CW)) bus ();

    branch_sched #(.CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .br_if (bus)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // External comparator model; unknown codes return 0.
    always_comb begin
        cmp_model = 1'b0;
        case (bus.cmp_type)
            CMP_EQ:  cmp_model = (bus.cmp_rd1 == bus.cmp_rd2);
            CMP_NE:  cmp_model = (bus.cmp_rd1 != bus.cmp_rd2);
            CMP_GTZ: cmp_model = ($signed(bus.cmp_rd1) > 0);
            CMP_LEZ: cmp_model = ($signed(bus.cmp_rd1) <= 0);
            CMP_GEZ: cmp_model = ($signed(bus.cmp_rd1) >= 0);
            CMP_LTZ: cmp_model = ($signed(bus.cmp_rd1) < 0);
            default: cmp_model = 1'b0;
        endcase
    end
    assign bus.cmp_out = cmp_force | cmp_model;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard: every redirect must match the oldest expected target.
    always @(negedge clk) begin
        if (bus.redirect_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL spurious_redirect actual=0x%08h expected=none", bus.redirect_pc);
            end else begin
                logic [31:0] want;
                want = exp_q.pop_front();
                if (bus.redirect_pc !== want) begin
                    failures++;
                    $display("FAIL sb_redirect_pc actual=0x%08h expected=0x%08h", bus.redirect_pc, want);
                end
            end
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.br_valid  = 1'b0;
        bus.br_type   = 4'h0;
        bus.rs_val    = 32'h0;
        bus.rt_val    = 32'h0;
        bus.rs_ready  = 1'b0;
        bus.rt_ready  = 1'b0;
        bus.br_target = 32'h0;
        bus.exc_flush = 1'b0;
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_taken_cnt"}, 32'(bus.taken_cnt), 32'(exp_taken));
        check({tag, "_ntaken_cnt"}, 32'(bus.ntaken_cnt), 32'(exp_ntaken));
    endtask

    // Issue one branch with both operands ready and follow it to completion.
    task automatic run_branch(input logic [3:0] t, input logic [31:0] rs, input logic [31:0] rt,
                              input logic [31:0] tgt, input logic taken, input string tag);
        check({tag, "_start_idle"}, 32'(bus.dbg_state), ST_IDLE);
        bus.br_valid  = 1'b1;
        bus.br_type   = t;
        bus.rs_val    = rs;
        bus.rt_val    = rt;
        bus.rs_ready  = 1'b1;
        bus.rt_ready  = 1'b1;
        bus.br_target = tgt;
        #1;
        check({tag, "_stall_n"}, 32'(bus.stall_d), 32'd1);
        check({tag, "_redir_n"}, 32'(bus.redirect_valid), 32'd0);
        if (taken) exp_q.push_back(tgt);
        tick();
        bus.br_valid = 1'b0;
        bus.rs_val   = ~rs;
        bus.rt_val   = ~rt;
        #1;
        check({tag, "_state_cmp"}, 32'(bus.dbg_state), ST_CMP);
        check({tag, "_stall_n1"}, 32'(bus.stall_d), 32'd1);
        check({tag, "_cmp_rd1"}, bus.cmp_rd1, rs);
        check({tag, "_cmp_rd2"}, bus.cmp_rd2, rt);
        check({tag, "_cmp_type"}, 32'(bus.cmp_type), 32'(t));
        tick();
        if (taken) exp_taken = exp_taken + 1'b1;
        else       exp_ntaken = exp_ntaken + 1'b1;
        #1;
        check({tag, "_redir_n2"}, 32'(bus.redirect_valid), 32'(taken));
        check({tag, "_pc_n2"}, bus.redirect_pc, taken ? tgt : 32'h0);
        check({tag, "_stall_n2"}, 32'(bus.stall_d), 32'd0);
        check({tag, "_state_n2"}, 32'(bus.dbg_state), taken ? ST_REDIR : ST_IDLE);
        check_counters(tag);
        if (taken) begin
            tick();
            #1;
            check({tag, "_redir_n3"}, 32'(bus.redirect_valid), 32'd0);
            check({tag, "_state_n3"}, 32'(bus.dbg_state), ST_IDLE);
        end
    endtask

    initial begin
        int stall_cycles;
        checks     = 0;
        failures   = 0;
        exp_taken  = '0;
        exp_ntaken = '0;
        cmp_force  = 1'b0;
        reset      = 1'b0;
        idle_inputs();

        vecs[0]  = '{CMP_EQ,  32'h5,        32'h5, 32'h3008, 1'b1};
        vecs[1]  = '{CMP_NE,  32'h7,        32'h7, 32'h3100, 1'b0};
        vecs[2]  = '{CMP_EQ,  32'h1,        32'h2, 32'h3200, 1'b0};
        vecs[3]  = '{CMP_NE,  32'h1,        32'h2, 32'h4000, 1'b1};
        vecs[4]  = '{CMP_GTZ, 32'hFFFFFFFF, 32'h0, 32'h4010, 1'b0};
        vecs[5]  = '{CMP_GTZ, 32'h0,        32'h0, 32'h4020, 1'b0};
        vecs[6]  = '{CMP_LEZ, 32'h0,        32'h0, 32'h4100, 1'b1};
        vecs[7]  = '{CMP_GEZ, 32'h80000000, 32'h0, 32'h4110, 1'b0};
        vecs[8]  = '{CMP_LTZ, 32'h80000000, 32'h0, 32'h4200, 1'b1};
        vecs[9]  = '{CMP_BAD, 32'h5,        32'h5, 32'h4210, 1'b0};
        vecs[10] = '{CMP_GTZ, 32'h7FFFFFFF, 32'h0, 32'h4300, 1'b1};

        // Reset state, with br_valid high to show stall_d is held low.
        tick();
        bus.br_valid = 1'b1;
        #1;
        check("rst_stall", 32'(bus.stall_d), 32'd0);
        check("rst_redir", 32'(bus.redirect_valid), 32'd0);
        check("rst_pc", bus.redirect_pc, 32'h0);
        check("rst_state", 32'(bus.dbg_state), ST_IDLE);
        check_counters("rst");
        bus.br_valid = 1'b0;
        tick();
        reset = 1'b1;

        // Back-to-back table vectors, first one on the first edge after release.
        for (int i = 0; i < 11; i++) begin
            run_branch(vecs[i].br_type, vecs[i].rs, vecs[i].rt, vecs[i].target,
                       vecs[i].taken, $sformatf("v%0d", i));
        end

        // Operands pending: rs not ready for 3 cycles, latched on the ready cycle.
        stall_cycles = 0;
        exp_q.push_back(32'h5000);
        bus.br_valid  = 1'b1;
        bus.br_type   = CMP_GTZ;
        bus.br_target = 32'h5000;
        bus.rt_ready  = 1'b1;
        bus.rt_val    = 32'h0;
        bus.rs_ready  = 1'b0;
        bus.rs_val    = 32'hDEAD0000;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (bus.stall_d === 1'b1) stall_cycles++;
            if (c == 1 || c == 2 || c == 3) check($sformatf("wait_state_c%0d", c), 32'(bus.dbg_state), ST_WAIT);
            if (c == 4) check("wait_cmp_rd1", bus.cmp_rd1, 32'h1);
            if (c == 5) begin
                check("wait_redir", 32'(bus.redirect_valid), 32'd1);
                check("wait_pc", bus.redirect_pc, 32'h5000);
            end
            tick();
            bus.br_valid = 1'b0;
            bus.rs_ready = (c == 2);
            bus.rs_val   = (c == 2) ? 32'h1 : 32'hFFFFFFF0;
        end
        exp_taken = exp_taken + 1'b1;
        check("wait_stall_cycles", 32'(stall_cycles), 32'd5);
        check_counters("wait");
        idle_inputs();

        // Flush while in CMP with a forced taken result.
        bus.br_valid = 1'b1;
        bus.br_type  = CMP_EQ;
        bus.rs_val   = 32'h5;
        bus.rt_val   = 32'h5;
        bus.rs_ready = 1'b1;
        bus.rt_ready = 1'b1;
        bus.br_target = 32'h6000;
        tick();
        bus.br_valid  = 1'b0;
        bus.exc_flush = 1'b1;
        cmp_force     = 1'b1;
        #1;
        check("flush_cmp_stall", 32'(bus.stall_d), 32'd0);
        tick();
        bus.exc_flush = 1'b0;
        cmp_force     = 1'b0;
        #1;
        check("flush_cmp_redir", 32'(bus.redirect_valid), 32'd0);
        check("flush_cmp_state", 32'(bus.dbg_state), ST_IDLE);
        check_counters("flush_cmp");

        // Flush beats br_valid in IDLE: nothing captured.
        bus.br_valid  = 1'b1;
        bus.exc_flush = 1'b1;
        bus.br_type   = CMP_NE;
        bus.rs_val    = 32'h1;
        bus.rt_val    = 32'h2;
        #1;
        check("flush_idle_stall", 32'(bus.stall_d), 32'd0);
        tick();
        idle_inputs();
        #1;
        check("flush_idle_state", 32'(bus.dbg_state), ST_IDLE);
        check("flush_idle_type", 32'(bus.cmp_type), 32'(CMP_EQ));
        check("flush_idle_rd1", bus.cmp_rd1, 32'h5);

        // br_valid during REDIR is ignored, then accepted once back in IDLE.
        run_branch(CMP_EQ, 32'h3, 32'h3, 32'h7000, 1'b0 == 1'b1 ? 1'b0 : 1'b1, "pre_ign");
        exp_q.push_back(32'h7004);
        bus.br_valid  = 1'b1;
        bus.br_type   = CMP_EQ;
        bus.rs_val    = 32'h9;
        bus.rt_val    = 32'h9;
        bus.rs_ready  = 1'b1;
        bus.rt_ready  = 1'b1;
        bus.br_target = 32'h7004;
        tick();
        bus.br_valid = 1'b0;
        tick();
        #1;
        check("ign_state_redir", 32'(bus.dbg_state), ST_REDIR);
        bus.br_valid  = 1'b1;
        bus.br_type   = CMP_NE;
        bus.rs_val    = 32'h1;
        bus.rt_val    = 32'h2;
        bus.br_target = 32'h7008;
        #1;
        check("ign_redir_stall", 32'(bus.stall_d), 32'd0);
        tick();
        #1;
        check("ign_state_idle", 32'(bus.dbg_state), ST_IDLE);
        check("ign_idle_stall", 32'(bus.stall_d), 32'd1);
        exp_q.push_back(32'h7008);
        tick();
        bus.br_valid = 1'b0;
        #1;
        check("ign_accept_cmp", 32'(bus.dbg_state), ST_CMP);
        check("ign_accept_type", 32'(bus.cmp_type), 32'(CMP_NE));
        tick();
        tick();
        exp_taken = exp_taken + 2'd2;
        check_counters("ign");
        idle_inputs();

        // Asynchronous reset in WAIT discards the branch.
        bus.br_valid  = 1'b1;
        bus.br_type   = CMP_EQ;
        bus.rs_val    = 32'hA;
        bus.rt_val    = 32'hA;
        bus.rt_ready  = 1'b1;
        bus.br_target = 32'h8000;
        tick();
        bus.br_valid = 1'b0;
        #1;
        check("arst_pre_state", 32'(bus.dbg_state), ST_WAIT);
        check("arst_pre_stall", 32'(bus.stall_d), 32'd1);
        #1;
        reset = 1'b0;
        bus.rs_ready = 1'b1;
        #1;
        check("arst_stall", 32'(bus.stall_d), 32'd0);
        check("arst_redir", 32'(bus.redirect_valid), 32'd0);
        check("arst_pc", bus.redirect_pc, 32'h0);
        check("arst_rd1", bus.cmp_rd1, 32'h0);
        check("arst_rd2", bus.cmp_rd2, 32'h0);
        check("arst_type", 32'(bus.cmp_type), 32'h0);
        check("arst_state", 32'(bus.dbg_state), ST_IDLE);
        exp_taken  = '0;
        exp_ntaken = '0;
        check_counters("arst");
        tick();
        tick();
        idle_inputs();
        reset = 1'b1;
        run_branch(CMP_NE, 32'h1, 32'h1, 32'h8100, 1'b0, "post_rst");

        // Taken counter wraps modulo 16.
        for (int k = 0; k < 16; k++) begin
            run_branch(CMP_EQ, 32'(k), 32'(k), 32'h9000 + 32'(k * 4), 1'b1, $sformatf("wrap%0d", k));
        end
        check("wrap_taken_zero", 32'(bus.taken_cnt), 32'h0);

        tick();
        check("pending_redirects", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
